// File: rtl/igbt_pulse_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : igbt_pulse_sequencer                                          |
// | Description : N-channel IGBT gate-pulse sequencer. Per-channel delay/width  |
// |               windows inside a programmable period, repeated for a burst    |
// |               count (0 = continuous). All timing inputs are shadowed at     |
// |               start so live PIO writes never disturb a running burst.       |
// |               Optional half-bridge interlock: IGBT_PULSE_INTERLOCK_EN       |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module igbt_pulse_sequencer #(
    parameter int N_CH = 4,
    parameter int W    = 32
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [N_CH*W-1:0] ch_delay,
    input  logic [N_CH*W-1:0] ch_width,
    input  logic [W-1:0]      period,
    input  logic [15:0]       burst_count,
    input  logic              ctrl_start,
    input  logic              ctrl_abort,
    output logic [N_CH-1:0]   pulse_out,
    output logic              busy,
    output logic              done,
    output logic              fault
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              start_q;
    logic [W-1:0]      t_q, t_d;
    logic [W-1:0]      period_q, period_d;
    logic [15:0]       bursts_q, bursts_d;
    logic [15:0]       burst_count_q, burst_count_d;
    logic [N_CH*W-1:0] delay_q, delay_d;
    logic [N_CH*W-1:0] width_q, width_d;
    logic [N_CH-1:0]   pulse_q, pulse_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;

    logic              start_rise;
    logic              t_last;
    logic              conflict;
    logic [N_CH-1:0]   hit;
    logic [N_CH-1:0]   gated;

    assign start_rise = ctrl_start & ~start_q;
    // period_q is never 0 while in RUN, so the subtraction cannot underflow there
    assign t_last     = (t_q == (period_q - W'(1)));

    // Window compare per channel; sum kept at W+1 bits so a large delay+width never wraps
    for (genvar i = 0; i < N_CH; i++) begin : g_hit
        logic [W:0] win_end;
        assign win_end = {1'b0, delay_q[i*W +: W]} + {1'b0, width_q[i*W +: W]};
        assign hit[i]  = (t_q >= delay_q[i*W +: W]) && ({1'b0, t_q} < win_end);
    end

`ifdef IGBT_PULSE_INTERLOCK_EN
    if ((N_CH % 2) != 0) begin : g_odd_channels
        $error("igbt_pulse_sequencer: N_CH must be even when the interlock is enabled");
    end

    logic [(N_CH+1)/2-1:0] pair_conflict;

    // Complementary pair 2k/2k+1: simultaneous demand blanks both legs for that cycle
    for (genvar k = 0; k < N_CH/2; k++) begin : g_pair
        assign pair_conflict[k] = hit[2*k] & hit[2*k+1];
        assign gated[2*k]       = hit[2*k]   & ~pair_conflict[k];
        assign gated[2*k+1]     = hit[2*k+1] & ~pair_conflict[k];
    end

    assign conflict = |pair_conflict;
`else
    assign gated    = hit;
    assign conflict = 1'b0;
`endif

    // State, counters, shadow copies and registered outputs
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q       <= S_IDLE;
            start_q       <= 1'b0;
            t_q           <= '0;
            period_q      <= '0;
            bursts_q      <= '0;
            burst_count_q <= '0;
            delay_q       <= '0;
            width_q       <= '0;
            pulse_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= ctrl_start;
            t_q           <= t_d;
            period_q      <= period_d;
            bursts_q      <= bursts_d;
            burst_count_q <= burst_count_d;
            delay_q       <= delay_d;
            width_q       <= width_d;
            pulse_q       <= pulse_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            fault_q       <= fault_d;
        end
    end

    // Next-state, counter and output decode; abort overrides everything last
    always_comb begin
        state_d       = state_q;
        t_d           = t_q;
        period_d      = period_q;
        bursts_d      = bursts_q;
        burst_count_d = burst_count_q;
        delay_d       = delay_q;
        width_d       = width_q;
        fault_d       = fault_q;
        pulse_d       = '0;

        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                period_d      = period;
                burst_count_d = burst_count;
                delay_d       = ch_delay;
                width_d       = ch_width;
                t_d           = '0;
                bursts_d      = '0;
                fault_d       = 1'b0;
                // Decide from the live input: it is the value being shadowed this cycle
                state_d       = (period == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                pulse_d = gated;
                fault_d = fault_q | conflict;
                if (t_last) begin
                    if ((burst_count_q != 16'd0) &&
                        (({1'b0, bursts_q} + 17'd1) == {1'b0, burst_count_q})) begin
                        state_d = S_DONE;
                    end else begin
                        t_d = '0;
                        // Only continuous mode can reach the top; hold it there
                        if (bursts_q != 16'hFFFF) begin
                            bursts_d = bursts_q + 16'd1;
                        end
                    end
                end else begin
                    t_d = t_q + W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (ctrl_abort) begin
            state_d = S_IDLE;
            pulse_d = '0;
            fault_d = fault_q;
        end

        busy_d = (state_d == S_LOAD) || (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    assign pulse_out = pulse_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fault     = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_igbt_pulse_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_igbt_pulse_sequencer                                       |
// | Description : Scoreboard bench for igbt_pulse_sequencer. A behavioural      |
// |               model predicts the outputs after every clock edge from the    |
// |               time elapsed since the accepted start; a monitor compares.    |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_igbt_pulse_sequencer;

    localparam int     N_CH    = 4;
    localparam int     W       = 32;
    localparam longint FOREVER = 64'h0000_7fff_ffff_ffff;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N_CH*W-1:0] ch_delay;
    logic [N_CH*W-1:0] ch_width;
    logic [W-1:0]      period;
    logic [15:0]       burst_count;
    logic              ctrl_start;
    logic              ctrl_abort;
    logic [N_CH-1:0]   pulse_out;
    logic              busy;
    logic              done;
    logic              fault;

    always #5 clk = ~clk;

    igbt_pulse_sequencer #(.N_CH(N_CH), .W(W)) dut (
        .clk_clk      (clk),
        .reset_reset_n(rst_n),
        .ch_delay     (ch_delay),
        .ch_width     (ch_width),
        .period       (period),
        .burst_count  (burst_count),
        .ctrl_start   (ctrl_start),
        .ctrl_abort   (ctrl_abort),
        .pulse_out    (pulse_out),
        .busy         (busy),
        .done         (done),
        .fault        (fault)
    );

    typedef struct packed {
        logic [N_CH-1:0] p;
        logic            b;
        logic            d;
        logic            f;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: outputs follow from m = cycles since accepted start
    int     edge_no    = 0;
    bit     active     = 1'b0;
    int     s_edge     = 0;
    longint tot        = 0;
    longint per        = 0;
    longint dl[N_CH];
    longint wd[N_CH];
    bit     f_m        = 1'b0;
    bit     start_prev = 1'b0;

    function automatic logic [N_CH-1:0] hits(input longint t);
        logic [N_CH-1:0] h;
        h = '0;
        for (int i = 0; i < N_CH; i++) h[i] = (t >= dl[i]) && (t < dl[i] + wd[i]);
        return h;
    endfunction

    always @(posedge clk) begin : p_model
        exp_t            x;
        longint          m;
        longint          nb;
        logic [N_CH-1:0] h;
        bit              rise;
        bit              nonidle;
        x = '0;
        edge_no++;
        if (!rst_n) begin
            active     = 1'b0;
            start_prev = 1'b0;
            f_m        = 1'b0;
        end else begin
            rise       = ctrl_start && !start_prev;
            start_prev = ctrl_start;
            nonidle    = active && (longint'(edge_no - s_edge) <= tot + 2);
            if (ctrl_abort) begin
                active = 1'b0;
            end else begin
                if (!nonidle && rise) begin
                    active = 1'b1;
                    s_edge = edge_no;
                    tot    = FOREVER;
                end
                if (active) begin
                    m = longint'(edge_no - s_edge) + 1;
                    if (m == 2) begin
                        per = longint'(period);
                        nb  = longint'(burst_count);
                        for (int i = 0; i < N_CH; i++) begin
                            dl[i] = longint'(ch_delay[i*W +: W]);
                            wd[i] = longint'(ch_width[i*W +: W]);
                        end
                        tot = (per == 0) ? 0 : ((nb == 0) ? FOREVER : per * nb);
                        f_m = 1'b0;
                    end
                    if (m > tot + 2) begin
                        active = 1'b0;
                    end else begin
                        x.b = (m <= tot + 1);
                        x.d = (m == tot + 2);
                        if (m >= 3) begin
                            h = hits((m - 3) % per);
`ifdef IGBT_PULSE_INTERLOCK_EN
                            for (int k = 0; k < N_CH/2; k++) begin
                                if (h[2*k] && h[2*k+1]) begin
                                    h[2*k]   = 1'b0;
                                    h[2*k+1] = 1'b0;
                                    f_m      = 1'b1;
                                end
                            end
`endif
                            x.p = h;
                        end
                    end
                end
            end
        end
        x.f = f_m;
        exp_q.push_back(x);
    end

    // Monitor: one expected entry per edge, compared mid-cycle
    always @(negedge clk) begin : p_mon
        exp_t x;
        if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            check("pulse_out", longint'(pulse_out), longint'(x.p));
            check("busy",      longint'(busy),      longint'(x.b));
            check("done",      longint'(done),      longint'(x.d));
            check("fault",     longint'(fault),     longint'(x.f));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ch(input int i, input int d, input int w);
        ch_delay[i*W +: W] = W'(d);
        ch_width[i*W +: W] = W'(w);
    endtask

    task automatic start_pulse();
        ctrl_start = 1'b1;
        tick(2);
        ctrl_start = 1'b0;
    endtask

    initial begin : p_stim
        int len;
        int r;
        rst_n       = 1'b0;
        ctrl_start  = 1'b0;
        ctrl_abort  = 1'b0;
        period      = '0;
        burst_count = '0;
        ch_delay    = '0;
        ch_width    = '0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Basic single pulse
        set_ch(0, 2, 3); period = 10; burst_count = 1;
        start_pulse(); tick(16);

        // Burst of three with a window truncated at the period edge
        ch_delay = '0; ch_width = '0;
        set_ch(1, 6, 5); period = 8; burst_count = 3;
        start_pulse(); tick(30);

        // Zero period, then zero width / delay beyond period
        period = 0; burst_count = 1; set_ch(0, 0, 4);
        start_pulse(); tick(4);
        period = 10; set_ch(0, 3, 0); set_ch(1, 12, 3); set_ch(2, 1, 2);
        start_pulse(); tick(14);

        // Continuous: live edits, retrigger, then abort
        ch_delay = '0; ch_width = '0;
        set_ch(0, 1, 4); period = 10; burst_count = 0;
        start_pulse(); tick(8);
        set_ch(0, 0, 9); period = 5; tick(10);
        start_pulse(); tick(7);
        ctrl_abort = 1'b1; tick(2); ctrl_abort = 1'b0; tick(3);

        // Overlapping pair windows, run twice
        ch_delay = '0; ch_width = '0;
        set_ch(0, 0, 5); set_ch(1, 4, 3); period = 10; burst_count = 2;
        start_pulse(); tick(25);
        start_pulse(); tick(14);

        // Randomized bursts with live input noise and occasional abort
        for (int it = 0; it < 40; it++) begin
            period      = W'($urandom_range(0, 12));
            burst_count = 16'($urandom_range(0, 3));
            for (int i = 0; i < N_CH; i++) set_ch(i, int'($urandom_range(0, 13)), int'($urandom_range(0, 6)));
            len = (burst_count == 0) ? int'($urandom_range(5, 40))
                                     : int'(period) * int'(burst_count) + 4 + int'($urandom_range(0, 3));
            ctrl_start = 1'b1;
            for (int c = 0; c < len; c++) begin
                tick(1);
                r = int'($urandom_range(0, 99));
                if (r < 8)       ctrl_start = ~ctrl_start;
                else if (r < 14) set_ch(int'($urandom_range(0, N_CH-1)), int'($urandom_range(0, 13)), int'($urandom_range(0, 6)));
                else if (r < 17) period = W'($urandom_range(0, 12));
                else if (r == 99) begin
                    ctrl_abort = 1'b1; tick(1); ctrl_abort = 1'b0;
                end
            end
            ctrl_abort = 1'b1; ctrl_start = 1'b0;
            tick(1);
            ctrl_abort = 1'b0;
            tick(1);
        end

        // Asynchronous reset in the middle of a pulse
        ch_delay = '0; ch_width = '0;
        set_ch(0, 0, 8); period = 10; burst_count = 2;
        start_pulse(); tick(4);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pulse", longint'(pulse_out), 0);
        check("async_rst_busy",  longint'(busy),      0);
        check("async_rst_done",  longint'(done),      0);
        tick(2);
        rst_n = 1'b1;
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/igbt_pulse_sequencer.md
# igbt_pulse_sequencer

Parametrised N-channel IGBT gate-pulse sequencer. It sits in the FPGA fabric downstream of the HPS-driven pulse-length PIO exports. Per channel it takes a delay and a width, and globally a period, a burst count and control bits. It produces cycle-accurate, phase-aligned gate pulses, repeated for a programmed number of periods. All parameters are shadowed at start, so HPS writes during a burst never glitch the outputs.

## Interface
- `N_CH`, default 4: channel count, 1–36 (must be even when interlock is compiled in).
- `W`, default 32: width of the timing fields, in clock cycles.
- `clk_clk`, in, 1: fabric clock. All logic is on its rising edge.
- `reset_reset_n`, in, 1: asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `ch_delay`, in, N_CH*W: per-channel delay from period start; channel i is bits [i*W +: W].
- `ch_width`, in, N_CH*W: per-channel high time, same packing as `ch_delay`.
- `period`, in, W: period length in cycles.
- `burst_count`, in, 16: number of periods to run; 0 means continuous.
- `ctrl_start`, in, 1: level from the PIO. Its rising edge starts a burst.
- `ctrl_abort`, in, 1: level. While high, the block forces IDLE.
- `pulse_out`, out, N_CH: registered gate drives.
- `busy`, out, 1: high in the LOAD and RUN states.
- `done`, out, 1: one-cycle strobe at normal burst completion.
- `fault`, out, 1: sticky interlock violation flag.

## Operation
- Start detection: `start_rise` = `ctrl_start` & ~`start_q`, where `start_q` is `ctrl_start` registered. `start_q` resets to 0.
- FSM states: IDLE, LOAD, RUN, DONE.
  - IDLE → LOAD on `start_rise` when `ctrl_abort` is low.
  - LOAD (1 cycle): copy all inputs to shadow registers, set t=0 and bursts=0, clear `fault`. If the shadow period is 0, go to DONE; otherwise go to RUN.
  - RUN: t increments each cycle.
    - At t == period−1 with burst_count ≠ 0 and bursts+1 == burst_count: go to DONE.
    - Otherwise at t == period−1: t wraps to 0 and bursts increments (16-bit). In continuous mode bursts saturates rather than wrapping.
  - DONE (1 cycle): `done`=1, then go to IDLE.
- Channel compare, evaluated in RUN only:
  - `hit_i` = (t ≥ delay_i) && (t < delay_i + width_i).
  - The sum is computed in W+1 bits, so no overflow is possible.
  - width 0 gives no pulse. delay ≥ period gives no pulse.
  - A window extending past period−1 is truncated at the period boundary; it does not carry into the next period.
- `pulse_out[i]` is registered from `hit_i`. It is 0 in every state other than RUN-derived cycles.
- Abort:
  - `ctrl_abort` high in any state forces IDLE on the next edge and `pulse_out` to 0 on that same edge.
  - `done` is not asserted on abort.
  - `start_rise` is ignored while `ctrl_abort` is high.
- `ctrl_start` rising during LOAD, RUN or DONE is ignored. There is no queueing.
- Input changes after LOAD have no effect until the next start.

## Timing
- Reset values: `pulse_out`=0, `busy`=0, `done`=0, `fault`=0, state=IDLE, t=0, bursts=0, all shadow registers 0.
- Let cycle 0 be the edge at which `ctrl_start`=1 is first sampled after a low.
  - LOAD at cycle 1.
  - First RUN cycle (t=0) at cycle 2.
  - `pulse_out[i]` is high from cycle 3+delay_i for width_i cycles in each period.
- Fixed latency from the t value to its pin is 1 cycle.
- `busy` rises at cycle 1 and falls in the DONE cycle. DONE follows the RUN cycle with t=period−1 of the last burst.
- Consecutive periods are seamless: there is no idle cycle between t=period−1 and t=0.
- Reset asserted mid-burst clears all outputs immediately (asynchronously).

## Configuration
- Macro: `IGBT_PULSE_INTERLOCK_EN`.
- When defined:
  - Channels 2k and 2k+1 form a complementary half-bridge pair.
  - If `hit_2k` and `hit_2k+1` are both 1, both outputs of that pair are forced to 0 for that cycle and `fault` is set.
  - `fault` stays set until the next LOAD or reset.
  - An odd `N_CH` is a compile-time error (generate-time `$error`).
- When undefined: channels are independent and `fault` is tied to 0.

## Test plan
- Basic pulse: N_CH=4, period=10, burst=1, ch0 delay=2/width=3, start rising at cycle 0.
  - pulse_out[0] high at cycles 5–7 only.
  - busy covers cycles 1–11.
  - done=1 at cycle 12.
- Burst and truncation: period=8, burst=3, ch1 delay=6/width=5.
  - ch1 high for exactly 2 cycles in each of the 3 periods (truncated).
  - Periods are contiguous.
  - done appears once, after the 24th RUN cycle.
- Zero and edge cases:
  - period=0 → done 2 cycles after start, no pulses.
  - width=0 or delay=12 with period=10 → that channel stays 0.
- Abort and shadowing:
  - burst=0 (continuous); change ch0 width mid-run → no effect.
  - ctrl_abort at t=4 → pulse_out=0 and busy=0 on the next edge, done never asserts.
  - Retrigger start during RUN → ignored.
- Interlock (macro defined): ch0 delay=0/width=5, ch1 delay=4/width=3, period=10.
  - Both outputs low at t=4; otherwise each runs as programmed.
  - fault=1 stays set, then clears at the next LOAD.
  - Without the macro: both outputs are high at t=4 and fault=0.
- Async reset: assert reset_reset_n=0 mid-pulse → all outputs 0 immediately, state returns to IDLE.
